// File: rtl/mod3_sched_pkg.sv
// ============================================================================
// Module      : mod3_sched_pkg
// Description : Shared types, constants and helpers for the 3-way arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod3_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] ID_NONE = 2'd3;

    // Out-of-range ids wrap to 0 so a corrupted pointer self-heals.
    function automatic logic [1:0] mod3_inc(input logic [1:0] id);
        return (id >= 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod3_rr_pick.sv
// ============================================================================
// Module      : mod3_rr_pick
// Description : Combinational round-robin winner select starting at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod3_rr_pick
    import mod3_sched_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [2:0] o_grant,
    output logic [1:0] o_id,
    output logic       o_valid
);

    logic [1:0] w_cand;
    logic [2:0] w_cand_oh;

    always_comb begin
        o_grant   = 3'b000;
        o_id      = ID_NONE;
        o_valid   = 1'b0;
        w_cand    = (i_ptr > 2'd2) ? 2'd0 : i_ptr;
        w_cand_oh = 3'b000;
        for (int k = 0; k < 3; k++) begin
            w_cand_oh = 3'b001 << w_cand;
            if (!o_valid && ((i_req & w_cand_oh) != 3'b000)) begin
                o_grant = w_cand_oh;
                o_id    = w_cand;
                o_valid = 1'b1;
            end
            w_cand = mod3_inc(w_cand);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mod3_rr_arbiter.sv
// ============================================================================
// Module      : mod3_rr_arbiter
// Description : Three-requester round-robin arbiter with hold-time limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod3_rr_arbiter
    import mod3_sched_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout
);

    localparam int                    c_hold_w    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_hold_w-1:0]   c_hold_last = c_hold_w'(MAX_HOLD - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_ptr;
    logic [1:0]          w_ptr_nxt;
    logic [c_hold_w-1:0] r_hold;
    logic [c_hold_w-1:0] w_hold_nxt;
    logic [2:0]          w_grant_nxt;
    logic [1:0]          w_id_nxt;
    logic                w_busy_nxt;
    logic                w_timeout_nxt;

    logic [2:0]          w_pick_grant;
    logic [1:0]          w_pick_id;
    logic                w_pick_valid;
    logic                w_owner_req;
    logic                w_hold_done;

    mod3_rr_pick u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_id    (w_pick_id),
        .o_valid (w_pick_valid)
    );

    assign w_owner_req = ((req & grant) != 3'b000);
    assign w_hold_done = (r_hold == c_hold_last);

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        w_grant_nxt   = grant;
        w_id_nxt      = grant_id;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = w_pick_grant;
                    w_id_nxt    = w_pick_id;
                    w_hold_nxt  = '0;
                end else begin
                    w_grant_nxt = 3'b000;
                    w_id_nxt    = ID_NONE;
                end
            end
            GRANT: begin
                if (done || !w_owner_req || w_hold_done) begin
                    w_state_nxt   = RELEASE;
                    w_grant_nxt   = 3'b000;
                    w_id_nxt      = ID_NONE;
                    w_ptr_nxt     = mod3_inc(grant_id);
                    w_hold_nxt    = '0;
                    // Forced release only when nothing else ended the tenure.
                    w_timeout_nxt = w_hold_done && !done && w_owner_req;
                end else begin
                    w_hold_nxt = r_hold + c_hold_w'(1);
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 3'b000;
                w_id_nxt    = ID_NONE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 3'b000;
                w_id_nxt    = ID_NONE;
                w_hold_nxt  = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= 2'd0;
            r_hold   <= '0;
            grant    <= 3'b000;
            grant_id <= ID_NONE;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_hold   <= w_hold_nxt;
            grant    <= w_grant_nxt;
            grant_id <= w_id_nxt;
            busy     <= w_busy_nxt;
            timeout  <= w_timeout_nxt;
        end
    end

endmodule

`default_nettype wire

// File: doc/mod3_rr_arbiter.md
MOD3_RR_ARBITER -- requirements
Module: mod3_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, meaning: max grant cycles before forced release; legal range 2..255.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req  input  3  request per requester 0..2; level, held until granted.
REQ-005 done  input  1  shared-resource completion; one-cycle pulse from the current owner.
REQ-006 grant  output  3  one-hot grant; all-zero when no grant.
REQ-007 grant_id  output  2  index of granted requester 0..2; 2'd3 when no grant.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-010 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-011 The FSM SHALL have states IDLE, GRANT and RELEASE.
REQ-012 IDLE, req != 0: winner = first set bit in the order ptr, ptr+1, ptr+2 (mod 3); grant and grant_id update at the next edge; next state GRANT.
REQ-013 IDLE, req == 0: the FSM SHALL stay in IDLE with all outputs at their idle values.
REQ-014 Grant latency SHALL be exactly 1 cycle from the first IDLE cycle in which req is sampled.
REQ-015 hold_cnt SHALL be 0 in the first GRANT cycle and increment by 1 each further GRANT cycle.
REQ-016 GRANT release SHALL occur on any of:
  - done=1;
  - req[grant_id]=0;
  - hold_cnt == MAX_HOLD-1.
REQ-017 At release, next state is RELEASE and ptr <= (grant_id+1) mod 3.
REQ-018 timeout SHALL pulse for 1 cycle, coincident with the RELEASE cycle, only when release is due solely to hold_cnt; done or req drop in the same cycle suppresses timeout.
REQ-019 RELEASE SHALL drive grant=0 and grant_id=3 for exactly 1 cycle, then go unconditionally to IDLE. Minimum gap between grants: 2 cycles.
REQ-020 done SHALL be ignored in IDLE and RELEASE.
REQ-021 Changes on non-granted req bits during GRANT SHALL NOT affect the current grant.
REQ-022 ptr SHALL take only the values 0..2 and SHALL change only at release.
REQ-023 grant SHALL never have more than one bit set.

Reset
REQ-024 On rst=1 at a clock edge:
  - state=IDLE, ptr=0, hold_cnt=0;
  - grant=3'b000, grant_id=2'd3, busy=0, timeout=0.
REQ-025 Reset SHALL override every other input, including mid-GRANT; the grant drops at that edge, and timeout and ptr advance are not produced.
REQ-026 The first arbitration after reset SHALL favour requester 0.

Structure
REQ-027 Package mod3_sched_pkg SHALL hold:
  - state enum (IDLE, GRANT, RELEASE);
  - constant ID_NONE = 2'd3;
  - function mod3_inc(id) returning (id+1) mod 3.
REQ-028 One combinational sub-module, mod3_rr_pick, SHALL compute the winner one-hot and index from req and ptr; the FSM, hold counter and output registers live in mod3_rr_arbiter.
REQ-029 hold_cnt width SHALL be $clog2(MAX_HOLD).

Verification
REQ-030 Reset then req=3'b111 held, done pulsed in the 3rd GRANT cycle of each grant:
  - grant_id sequence 0,1,2,0;
  - each grant separated by exactly 2 idle cycles;
  - timeout never set.
REQ-031 MAX_HOLD=8, req=3'b010, done never asserted:
  - grant=3'b010 for exactly 8 cycles;
  - timeout pulses once in the RELEASE cycle;
  - regrant to 1 two cycles later.
REQ-032 Owner 0 drops req[0] in its 2nd GRANT cycle while req=3'b101:
  - release, no timeout;
  - next grant goes to requester 2.
REQ-033 done and hold_cnt==MAX_HOLD-1 in the same cycle -> single release, timeout=0.
REQ-034 rst asserted mid-GRANT of requester 2:
  - next edge grant=0, grant_id=3, busy=0;
  - after rst deasserts with req=3'b111, first grant is to requester 0.
REQ-035 Assertions on every cycle:
  - grant is one-hot or zero;
  - grant_id == 3 exactly when grant == 0;
  - busy == (state != IDLE).
